// File: rtl/simple_ram_arbiter.sv
// -----------------------------------------------------------------------------
// simple_ram_arbiter
//
// Round-robin arbiter that lets two requesters share one single-port,
// synchronous RAM. Each requester issues read/write commands over a
// valid/ready handshake and gets read data back on its own response port.
// At most one command is accepted per cycle. Read data returns a fixed two
// cycles after acceptance: one cycle to register the command onto the RAM
// pins, one cycle for the RAM's registered read.
//
// Ports:
//   clk, rst                 rising-edge clock; synchronous active-high reset
//   reqN_valid/ready         command handshake for port N (N = 0, 1)
//   reqN_we                  1 = write, 0 = read
//   reqN_addr, reqN_wdata    command address and write data
//   rspN_valid, rspN_rdata   read response for port N (rdata is 0 when idle)
//   ram_we, ram_addr,        registered command driven into the RAM
//   ram_data_in
//   ram_data_out             registered read data coming back from the RAM
// -----------------------------------------------------------------------------
module simple_ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,

  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  // Port that won the most recent accepted command. Resets to 1 so that
  // port 0 wins the first tie.
  logic last_grant_reg;

  // Read-tracking pipeline: stage 1 lines up with the command on the RAM
  // pins, stage 2 lines up with the RAM's registered data_out.
  logic s1_rd_reg;
  logic s1_port_reg;
  logic s2_rd_reg;
  logic s2_port_reg;

  logic grant0;
  logic grant1;
  logic accept;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Grant is purely a function of the two valids and last_grant, so ready
  // never waits on anything downstream.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      // Tie: the port that did not win last time goes now.
      grant0 = last_grant_reg;
      grant1 = !last_grant_reg;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign accept     = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Command mux feeding the RAM pin registers.
  always_comb begin
    sel_we    = req0_we;
    sel_addr  = req0_addr;
    sel_wdata = req0_wdata;
    if (grant1) begin
      sel_we    = req1_we;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_data_in    <= '0;
      last_grant_reg <= 1'b1;
      s1_rd_reg      <= 1'b0;
      s1_port_reg    <= 1'b0;
      s2_rd_reg      <= 1'b0;
      s2_port_reg    <= 1'b0;
    end else begin
      if (accept) begin
        ram_we         <= sel_we;
        ram_addr       <= sel_addr;
        ram_data_in    <= sel_wdata;
        last_grant_reg <= grant1;
        s1_rd_reg      <= !sel_we;
        s1_port_reg    <= grant1;
      end else begin
        // Idle cycle: never write, but keep address/data steady so the RAM
        // pins do not toggle needlessly.
        ram_we    <= 1'b0;
        s1_rd_reg <= 1'b0;
      end
      s2_rd_reg   <= s1_rd_reg;
      s2_port_reg <= s1_port_reg;
    end
  end

  // Response fan-out: stage 2 steers ram_data_out to the owning port and
  // forces the other port's data to zero.
  logic [1:0]            rsp_valid_vec;
  logic [DATA_WIDTH-1:0] rsp_rdata_vec [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      assign rsp_valid_vec[gi] = s2_rd_reg && (s2_port_reg == 1'(gi));
      assign rsp_rdata_vec[gi] = rsp_valid_vec[gi] ? ram_data_out : '0;
    end
  endgenerate

  assign rsp0_valid = rsp_valid_vec[0];
  assign rsp0_rdata = rsp_rdata_vec[0];
  assign rsp1_valid = rsp_valid_vec[1];
  assign rsp1_rdata = rsp_rdata_vec[1];

endmodule

// File: tb/tb_simple_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_simple_ram_arbiter
//
// Drives directed per-cycle command vectors into simple_ram_arbiter, which
// sits in front of a behavioural single-port synchronous RAM. Every accepted
// read pushes its hand-computed expected response (port, data, cycle) into a
// queue; an independent monitor pops and compares whenever a response port
// is valid, and flags unexpected, missing or late responses.
// -----------------------------------------------------------------------------
module tb_simple_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;

  simple_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_we      (req0_we),
    .req0_addr    (req0_addr),
    .req0_wdata   (req0_wdata),
    .rsp0_valid   (rsp0_valid),
    .rsp0_rdata   (rsp0_rdata),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_we      (req1_we),
    .req1_addr    (req1_addr),
    .req1_wdata   (req1_wdata),
    .rsp1_valid   (rsp1_valid),
    .rsp1_rdata   (rsp1_rdata),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // Behavioural single-port synchronous RAM (read-before-write).
  logic [DW-1:0] mem [2**AW];
  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    ram_data_out = '0;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic [DW-1:0] data;
    int          when;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // One clock of stimulus. e0/e1 are the expected read data should the
  // command on that port be accepted; g0/g1 are the expected readies.
  task automatic drive(input logic v0, input logic we0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic [DW-1:0] e0,
                       input logic v1, input logic we1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1, input logic [DW-1:0] e1,
                       input logic g0, input logic g1);
    exp_t e;
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    @(negedge clk);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    $display("cycle %0d: rst=%0b p0(v=%0b we=%0b a=%0d) p1(v=%0b we=%0b a=%0d) ready=%0b%0b",
             cyc, rst, v0, we0, a0, v1, we1, a1, req0_ready, req1_ready);
    if (!rst && v0 && req0_ready && !we0) begin
      e.port = 0; e.data = e0; e.when = cyc + 2; exp_q.push_back(e);
    end
    if (!rst && v1 && req1_ready && !we1) begin
      e.port = 1; e.data = e1; e.when = cyc + 2; exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd0(input logic [AW-1:0] a, input logic [DW-1:0] e);
    drive(1, 0, a, 0, e, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1, 1, a, d, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // Monitor: pops one expectation per response pulse and checks port,
  // data and timing; idle response ports must read back zero.
  always @(negedge clk) begin
    if (mon_on) begin
      while (exp_q.size() > 0 && exp_q[0].when < cyc) begin
        n_checks++;
        $display("FAIL missed_rsp: port %0d data 0x%0h never seen, due cycle %0d now %0d",
                 exp_q[0].port, exp_q[0].data, exp_q[0].when, cyc);
        void'(exp_q.pop_front());
      end
      if (rsp0_valid || rsp1_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rsp: rsp0_valid=%0b rsp1_valid=%0b required none (cycle %0d)",
                   rsp0_valid, rsp1_valid, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("cycle %0d: rsp p0(v=%0b d=0x%0h) p1(v=%0b d=0x%0h) expect port %0d data 0x%0h",
                   cyc, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata, e.port, e.data);
          chk("rsp_cycle", cyc, e.when);
          chk("rsp_port", {30'd0, rsp1_valid, rsp0_valid}, (e.port == 0) ? 32'd1 : 32'd2);
          chk("rsp_rdata", (e.port == 0) ? {24'd0, rsp0_rdata} : {24'd0, rsp1_rdata},
              {24'd0, e.data});
        end
      end
      if (!rsp0_valid) chk("rsp0_idle_zero", {24'd0, rsp0_rdata}, 32'd0);
      if (!rsp1_valid) chk("rsp1_idle_zero", {24'd0, rsp1_rdata}, 32'd0);
    end
  end

  logic [AW-1:0] a0s [4];
  logic [DW-1:0] e0s [4];
  logic [AW-1:0] a1s [4];
  logic [DW-1:0] e1s [4];

  initial begin
    int i0;
    int i1;
    rst = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    idle(1);
    // Reset state.
    chk("reset_ram_we", {31'd0, ram_we}, 32'd0);
    chk("reset_ram_addr", {28'd0, ram_addr}, 32'd0);
    chk("reset_ram_data_in", {24'd0, ram_data_in}, 32'd0);
    chk("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    mon_on = 1'b1;
    rst = 1'b0;

    // Single read of address 4 (RAM still zero).
    rd0(4, 8'h00);
    chk("t1_ram_we", {31'd0, ram_we}, 32'd0);
    chk("t1_ram_addr", {28'd0, ram_addr}, 32'd4);
    idle(3);

    // Back-to-back writes then back-to-back reads on port 0, corners 0 and 15.
    wr0(4, 8'hAA);
    chk("t2_ram_we", {31'd0, ram_we}, 32'd1);
    chk("t2_ram_data_in", {24'd0, ram_data_in}, 32'hAA);
    wr0(8, 8'h55);
    wr0(15, 8'hFF);
    wr0(0, 8'h00);
    rd0(4, 8'hAA);
    rd0(8, 8'h55);
    rd0(15, 8'hFF);
    rd0(0, 8'h00);
    idle(3);

    // Reset with port 1 valid: ready may be high, but the acceptance is
    // discarded and port 0 still wins the first tie afterwards.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0, 8, 0, 8'h55, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 8, 0, 8'h55, 0, 1);
    rst = 1'b0;
    drive(1, 0, 4, 0, 8'hAA, 1, 0, 8, 0, 8'h55, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 8, 0, 8'h55, 0, 1);
    idle(3);

    // Both ports streaming reads: strict alternation starting at port 0.
    a0s = '{4'd4, 4'd8, 4'd15, 4'd0};  e0s = '{8'hAA, 8'h55, 8'hFF, 8'h00};
    a1s = '{4'd0, 4'd15, 4'd8, 4'd4};  e1s = '{8'h00, 8'hFF, 8'h55, 8'hAA};
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 8; k++) begin
      drive(i0 < 4, 0, a0s[i0 % 4], 0, e0s[i0 % 4],
            i1 < 4, 0, a1s[i1 % 4], 0, e1s[i1 % 4],
            (k % 2) == 0, (k % 2) == 1);
      if (k % 2 == 0) i0++;
      else i1++;
    end
    idle(3);

    // Read-after-write across ports.
    wr0(5, 8'h3C);
    drive(0, 0, 0, 0, 0, 1, 0, 5, 0, 8'h3C, 0, 1);
    idle(3);

    // Reset right after a read is accepted: the read must vanish.
    rd0(8, 8'h55);
    rst = 1'b1;
    exp_q.delete();
    idle(1);
    rst = 1'b0;
    idle(4);
    rd0(5, 8'h3C);
    rd0(15, 8'hFF);
    idle(4);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
